// File: rtl/fbuff_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fbuff_arbiter
//
// Single-port arbiter in front of the frame buffer BRAM. The display read
// client (line_buffers) and the host write client (frame loader) share the
// BRAM through this block. Reads win arbitration because the display is
// real-time. A burst counter limits how many reads may be granted back to
// back while a write is waiting, which bounds write starvation.
//
// Parameters
//   FBUFF_ADDR_WIDTH : BRAM address width
//   FBUFF_DATA_WIDTH : BRAM word width (4 tiles x 12-bit colour)
//   FBUFF_DEPTH      : number of valid rows; addresses >= this are rejected
//   RD_LATENCY       : BRAM read latency, enable-high cycle to valid douta
//   MAX_RD_BURST     : reads granted in a row while a write is pending
//
// Ports
//   clk_i, rstn_i               : pixel clock, async active-low reset
//   rd_req_i / rd_addr_i        : read request (level) and address
//   rd_rsp_o / rd_data_o        : one-cycle response pulse, held read data
//   wr_req_i / wr_addr_i / wr_data_i : write request (level), address, data
//   wr_ack_o                    : one-cycle pulse, write done or dropped
//   addr_err_o                  : one-cycle pulse, granted address out of range
//   fbuff_addra_o/dina_o/wea_o/ena_o : BRAM port A controls
//   fbuff_douta_i               : BRAM read data
//
// All outputs are registered and reset to zero.
// ---------------------------------------------------------------------------
module fbuff_arbiter #(
  parameter int FBUFF_ADDR_WIDTH = 13,
  parameter int FBUFF_DATA_WIDTH = 48,
  parameter int FBUFF_DEPTH      = 4800,
  parameter int RD_LATENCY       = 2,
  parameter int MAX_RD_BURST     = 8
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        rd_req_i,
  input  logic [FBUFF_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                        rd_rsp_o,
  output logic [FBUFF_DATA_WIDTH-1:0] rd_data_o,
  input  logic                        wr_req_i,
  input  logic [FBUFF_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [FBUFF_DATA_WIDTH-1:0] wr_data_i,
  output logic                        wr_ack_o,
  output logic                        addr_err_o,
  output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addra_o,
  output logic [FBUFF_DATA_WIDTH-1:0] fbuff_dina_o,
  output logic                        fbuff_wea_o,
  output logic                        fbuff_ena_o,
  input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_douta_i
);

  localparam int BURST_W = $clog2(MAX_RD_BURST + 1);
  localparam int WAIT_W  = $clog2(RD_LATENCY + 1);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_RD_BURST);
  localparam logic [WAIT_W-1:0]  WAIT_INIT = WAIT_W'(RD_LATENCY - 1);
  localparam logic [31:0]        DEPTH_U   = 32'(FBUFF_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_RSP,
    WR
  } state_t;

  state_t               state;
  logic [BURST_W-1:0]   burst_ctr;
  logic [WAIT_W-1:0]    wait_ctr;
  logic                 rd_oor;

  function automatic logic addr_oor(input logic [FBUFF_ADDR_WIDTH-1:0] addr);
    return 32'(addr) >= DEPTH_U;
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      burst_ctr     <= '0;
      wait_ctr      <= '0;
      rd_oor        <= 1'b0;
      rd_rsp_o      <= 1'b0;
      rd_data_o     <= '0;
      wr_ack_o      <= 1'b0;
      addr_err_o    <= 1'b0;
      fbuff_addra_o <= '0;
      fbuff_dina_o  <= '0;
      fbuff_wea_o   <= 1'b0;
      fbuff_ena_o   <= 1'b0;
    end else begin
      case (state)
        // Arbitration: read wins unless a write has waited out a full burst.
        IDLE: begin
          if (rd_req_i && (!wr_req_i || burst_ctr != BURST_MAX)) begin
            state         <= RD_ISSUE;
            rd_oor        <= addr_oor(rd_addr_i);
            fbuff_addra_o <= rd_addr_i;
            fbuff_ena_o   <= !addr_oor(rd_addr_i);
            fbuff_wea_o   <= 1'b0;
            // A read is only granted over a pending write while the counter
            // is below its limit, so the increment cannot overflow.
            burst_ctr     <= wr_req_i ? burst_ctr + 1'b1 : '0;
          end else if (wr_req_i) begin
            state         <= WR;
            burst_ctr     <= '0;
            fbuff_addra_o <= wr_addr_i;
            fbuff_dina_o  <= wr_data_i;
            fbuff_ena_o   <= !addr_oor(wr_addr_i);
            fbuff_wea_o   <= !addr_oor(wr_addr_i);
            wr_ack_o      <= 1'b1;
            addr_err_o    <= addr_oor(wr_addr_i);
          end
        end

        // BRAM samples the address at the end of this cycle.
        RD_ISSUE: begin
          fbuff_ena_o <= 1'b0;
          wait_ctr    <= WAIT_INIT;
          state       <= RD_WAIT;
        end

        // Counts the BRAM latency; douta is valid in the last wait cycle and
        // is captured on the edge that closes it.
        RD_WAIT: begin
          if (wait_ctr == '0) begin
            rd_data_o  <= rd_oor ? '0 : fbuff_douta_i;
            rd_rsp_o   <= 1'b1;
            addr_err_o <= rd_oor;
            state      <= RD_RSP;
          end else begin
            wait_ctr <= wait_ctr - 1'b1;
          end
        end

        RD_RSP: begin
          rd_rsp_o   <= 1'b0;
          addr_err_o <= 1'b0;
          state      <= IDLE;
        end

        WR: begin
          fbuff_ena_o <= 1'b0;
          fbuff_wea_o <= 1'b0;
          wr_ack_o    <= 1'b0;
          addr_err_o  <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fbuff_arbiter.sv
`timescale 1ns/1ps
module tb_fbuff_arbiter;

  logic        clk;
  logic        rstn;
  logic        rd_req;
  logic [12:0] rd_addr;
  logic        rd_rsp_o;
  logic [47:0] rd_data_o;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [47:0] wr_data;
  logic        wr_ack_o;
  logic        addr_err_o;
  logic [12:0] fbuff_addra_o;
  logic [47:0] fbuff_dina_o;
  logic        fbuff_wea_o;
  logic        fbuff_ena_o;
  logic [47:0] fbuff_douta;

  int n_checks = 0;
  int n_fail   = 0;

  fbuff_arbiter dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .rd_req_i      (rd_req),
    .rd_addr_i     (rd_addr),
    .rd_rsp_o      (rd_rsp_o),
    .rd_data_o     (rd_data_o),
    .wr_req_i      (wr_req),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .wr_ack_o      (wr_ack_o),
    .addr_err_o    (addr_err_o),
    .fbuff_addra_o (fbuff_addra_o),
    .fbuff_dina_o  (fbuff_dina_o),
    .fbuff_wea_o   (fbuff_wea_o),
    .fbuff_ena_o   (fbuff_ena_o),
    .fbuff_douta_i (fbuff_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: 4800 x 48, two-cycle read latency (address register plus
  // output register).
  logic [47:0] mem [0:4799];
  logic [47:0] rd_stage;
  initial begin
    rd_stage    = '0;
    fbuff_douta = '0;
  end
  always @(posedge clk) begin
    if (fbuff_ena_o && fbuff_addra_o < 13'd4800) begin
      if (fbuff_wea_o) mem[fbuff_addra_o] <= fbuff_dina_o;
      else             rd_stage <= mem[fbuff_addra_o];
    end
    fbuff_douta <= rd_stage;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [12:0] a, output logic [47:0] d, output logic e,
                         output logic saw_ena, output int lat);
    rd_req = 1'b1; rd_addr = a; saw_ena = 1'b0; lat = -1; d = '0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (fbuff_ena_o) saw_ena = 1'b1;
      if (rd_rsp_o) begin d = rd_data_o; e = addr_err_o; lat = i; break; end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (rd_rsp_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_rsp got %0b want 0", rd_rsp_o); end
    n_checks++; if (rd_data_o !== 48'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data_o); end
    n_checks++; if (wr_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack got %0b want 0", wr_ack_o); end
    n_checks++; if (addr_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got %0b want 0", addr_err_o); end
    n_checks++; if (fbuff_addra_o !== 13'h0) begin n_fail++; $display("FAIL reset_addra got %h want 0", fbuff_addra_o); end
    n_checks++; if (fbuff_dina_o !== 48'h0) begin n_fail++; $display("FAIL reset_dina got %h want 0", fbuff_dina_o); end
    n_checks++; if (fbuff_ena_o !== 1'b0 || fbuff_wea_o !== 1'b0) begin n_fail++; $display("FAIL reset_en got ena=%0b wea=%0b want 0/0", fbuff_ena_o, fbuff_wea_o); end
    rstn = 1'b1;
    tick();
    n_checks++; if (fbuff_ena_o !== 1'b0 || rd_rsp_o !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got ena=%0b rsp=%0b want 0/0", fbuff_ena_o, rd_rsp_o); end
  endtask

  task automatic test_single_read();
    rd_req = 1'b1; rd_addr = 13'd5;
    tick(); // cycle 1
    n_checks++; if (fbuff_ena_o !== 1'b1 || fbuff_wea_o !== 1'b0) begin n_fail++; $display("FAIL read_c1_en got ena=%0b wea=%0b want 1/0", fbuff_ena_o, fbuff_wea_o); end
    n_checks++; if (fbuff_addra_o !== 13'd5) begin n_fail++; $display("FAIL read_c1_addra got %0d want 5", fbuff_addra_o); end
    tick(); // cycle 2
    n_checks++; if (fbuff_ena_o !== 1'b0 || rd_rsp_o !== 1'b0) begin n_fail++; $display("FAIL read_c2 got ena=%0b rsp=%0b want 0/0", fbuff_ena_o, rd_rsp_o); end
    tick(); // cycle 3
    n_checks++; if (rd_rsp_o !== 1'b0) begin n_fail++; $display("FAIL read_c3_rsp got %0b want 0", rd_rsp_o); end
    tick(); // cycle 4
    n_checks++; if (rd_rsp_o !== 1'b1) begin n_fail++; $display("FAIL read_c4_rsp got %0b want 1", rd_rsp_o); end
    n_checks++; if (rd_data_o !== 48'hABC_DEF_123_456) begin n_fail++; $display("FAIL read_c4_data got %h want abcdef123456", rd_data_o); end
    n_checks++; if (addr_err_o !== 1'b0) begin n_fail++; $display("FAIL read_c4_err got %0b want 0", addr_err_o); end
    rd_req = 1'b0;
    tick(); // cycle 5
    n_checks++; if (rd_rsp_o !== 1'b0 || rd_data_o !== 48'hABC_DEF_123_456) begin n_fail++; $display("FAIL read_c5 got rsp=%0b data=%h want 0/abcdef123456", rd_rsp_o, rd_data_o); end
  endtask

  task automatic test_single_write();
    logic [47:0] d; logic e; logic se; int lat;
    wr_req = 1'b1; wr_addr = 13'd10; wr_data = 48'h1;
    tick(); // cycle 1
    n_checks++; if (fbuff_wea_o !== 1'b1 || fbuff_ena_o !== 1'b1 || wr_ack_o !== 1'b1) begin n_fail++; $display("FAIL write_c1 got wea=%0b ena=%0b ack=%0b want 1/1/1", fbuff_wea_o, fbuff_ena_o, wr_ack_o); end
    n_checks++; if (fbuff_addra_o !== 13'd10 || fbuff_dina_o !== 48'h1) begin n_fail++; $display("FAIL write_c1_bus got addra=%0d dina=%h want 10/1", fbuff_addra_o, fbuff_dina_o); end
    n_checks++; if (addr_err_o !== 1'b0) begin n_fail++; $display("FAIL write_c1_err got %0b want 0", addr_err_o); end
    wr_req = 1'b0;
    tick(); // cycle 2
    n_checks++; if (wr_ack_o !== 1'b0 || fbuff_wea_o !== 1'b0 || fbuff_ena_o !== 1'b0) begin n_fail++; $display("FAIL write_c2 got ack=%0b wea=%0b ena=%0b want 0/0/0", wr_ack_o, fbuff_wea_o, fbuff_ena_o); end
    n_checks++; if (fbuff_addra_o !== 13'd10) begin n_fail++; $display("FAIL write_hold_addra got %0d want 10", fbuff_addra_o); end
    do_read(13'd10, d, e, se, lat);
    n_checks++; if (d !== 48'h1 || lat !== 4) begin n_fail++; $display("FAIL write_readback got data=%h lat=%0d want 1/4", d, lat); end
    tick();
  endtask

  task automatic test_back_to_back_writes();
    wr_req = 1'b1; wr_addr = 13'd30; wr_data = 48'hAAAA_0000_0030;
    tick();
    n_checks++; if (wr_ack_o !== 1'b1 || fbuff_addra_o !== 13'd30) begin n_fail++; $display("FAIL b2b_w1 got ack=%0b addra=%0d want 1/30", wr_ack_o, fbuff_addra_o); end
    wr_addr = 13'd31; wr_data = 48'hBBBB_0000_0031;
    tick();
    n_checks++; if (wr_ack_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got ack=%0b want 0", wr_ack_o); end
    tick();
    n_checks++; if (wr_ack_o !== 1'b1 || fbuff_addra_o !== 13'd31) begin n_fail++; $display("FAIL b2b_w2 got ack=%0b addra=%0d want 1/31", wr_ack_o, fbuff_addra_o); end
    wr_req = 1'b0;
    tick();
    n_checks++; if (mem[30] !== 48'hAAAA_0000_0030 || mem[31] !== 48'hBBBB_0000_0031) begin n_fail++; $display("FAIL b2b_mem got %h %h want aaaa00000030 bbbb00000031", mem[30], mem[31]); end
  endtask

  task automatic test_starvation();
    int rsp_before; int ack_tick; logic rsp_after;
    wr_req = 1'b1; wr_addr = 13'd20; wr_data = 48'h5A5;
    rd_req = 1'b1; rd_addr = 13'd5;
    rsp_before = 0; ack_tick = -1;
    for (int i = 1; i <= 100 && ack_tick < 0; i++) begin
      tick();
      if (rd_rsp_o) rsp_before++;
      if (wr_ack_o) begin ack_tick = i; wr_req = 1'b0; end
    end
    n_checks++; if (rsp_before !== 8) begin n_fail++; $display("FAIL starve_rsp_count got %0d want 8", rsp_before); end
    n_checks++; if (ack_tick !== 41) begin n_fail++; $display("FAIL starve_ack_cycle got %0d want 41", ack_tick); end
    rsp_after = 1'b0;
    for (int i = 1; i <= 20 && !rsp_after; i++) begin
      tick();
      if (rd_rsp_o) rsp_after = 1'b1;
    end
    rd_req = 1'b0;
    n_checks++; if (rsp_after !== 1'b1 || rd_data_o !== 48'hABC_DEF_123_456) begin n_fail++; $display("FAIL starve_resume got rsp=%0b data=%h want 1/abcdef123456", rsp_after, rd_data_o); end
    n_checks++; if (dut.burst_ctr !== 4'd0) begin n_fail++; $display("FAIL starve_burst_ctr got %0d want 0", dut.burst_ctr); end
    n_checks++; if (mem[20] !== 48'h5A5) begin n_fail++; $display("FAIL starve_mem got %h want 5a5", mem[20]); end
    tick();
  endtask

  task automatic test_simultaneous();
    logic got_rsp; logic got_ack;
    rd_req = 1'b1; rd_addr = 13'd7;
    wr_req = 1'b1; wr_addr = 13'd40; wr_data = 48'h77;
    tick();
    n_checks++; if (fbuff_ena_o !== 1'b1 || fbuff_wea_o !== 1'b0 || fbuff_addra_o !== 13'd7) begin n_fail++; $display("FAIL simul_read_first got ena=%0b wea=%0b addra=%0d want 1/0/7", fbuff_ena_o, fbuff_wea_o, fbuff_addra_o); end
    n_checks++; if (dut.burst_ctr !== 4'd1) begin n_fail++; $display("FAIL simul_burst_ctr got %0d want 1", dut.burst_ctr); end
    got_rsp = 1'b0;
    for (int i = 1; i <= 10 && !got_rsp; i++) begin
      tick();
      if (wr_ack_o) begin n_checks++; n_fail++; $display("FAIL simul_early_ack got 1 want 0"); end
      if (rd_rsp_o) got_rsp = 1'b1;
    end
    rd_req = 1'b0;
    n_checks++; if (got_rsp !== 1'b1 || rd_data_o !== 48'h7) begin n_fail++; $display("FAIL simul_read got rsp=%0b data=%h want 1/7", got_rsp, rd_data_o); end
    got_ack = 1'b0;
    for (int i = 1; i <= 10 && !got_ack; i++) begin
      tick();
      if (wr_ack_o) got_ack = 1'b1;
    end
    wr_req = 1'b0;
    tick();
    n_checks++; if (got_ack !== 1'b1 || mem[40] !== 48'h77) begin n_fail++; $display("FAIL simul_write got ack=%0b mem=%h want 1/77", got_ack, mem[40]); end
    n_checks++; if (dut.burst_ctr !== 4'd0) begin n_fail++; $display("FAIL simul_burst_clear got %0d want 0", dut.burst_ctr); end
  endtask

  task automatic test_out_of_range();
    logic [47:0] d; logic e; logic se; int lat; logic saw_wea; logic saw_err;
    do_read(13'd4800, d, e, se, lat);
    n_checks++; if (lat !== 4 || d !== 48'h0) begin n_fail++; $display("FAIL oor_read got lat=%0d data=%h want 4/0", lat, d); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_read_err got %0b want 1", e); end
    n_checks++; if (se !== 1'b0) begin n_fail++; $display("FAIL oor_read_ena got %0b want 0", se); end
    tick();
    wr_req = 1'b1; wr_addr = 13'd8191; wr_data = 48'hDEAD;
    tick();
    n_checks++; if (wr_ack_o !== 1'b1 || addr_err_o !== 1'b1) begin n_fail++; $display("FAIL oor_write got ack=%0b err=%0b want 1/1", wr_ack_o, addr_err_o); end
    saw_wea = fbuff_wea_o | fbuff_ena_o;
    wr_req = 1'b0;
    saw_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_wea |= fbuff_wea_o | fbuff_ena_o;
      saw_err |= addr_err_o | wr_ack_o;
    end
    n_checks++; if (saw_wea !== 1'b0) begin n_fail++; $display("FAIL oor_write_en got %0b want 0", saw_wea); end
    n_checks++; if (saw_err !== 1'b0) begin n_fail++; $display("FAIL oor_pulse_len got %0b want 0", saw_err); end
    n_checks++; if (mem[5] !== 48'hABC_DEF_123_456 || mem[10] !== 48'h1) begin n_fail++; $display("FAIL oor_mem got %h %h want abcdef123456 1", mem[5], mem[10]); end
  endtask

  task automatic test_reset_mid_read();
    int rsp_cnt; logic [47:0] d; logic e; logic se; int lat;
    rd_req = 1'b1; rd_addr = 13'd5;
    tick(); // RD_ISSUE
    tick(); // RD_WAIT
    rstn = 1'b0;
    #1;
    n_checks++; if (rd_rsp_o !== 1'b0 || fbuff_ena_o !== 1'b0 || fbuff_wea_o !== 1'b0 || wr_ack_o !== 1'b0 || addr_err_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got rsp=%0b ena=%0b wea=%0b ack=%0b err=%0b want 0", rd_rsp_o, fbuff_ena_o, fbuff_wea_o, wr_ack_o, addr_err_o); end
    n_checks++; if (fbuff_addra_o !== 13'h0 || fbuff_dina_o !== 48'h0 || rd_data_o !== 48'h0) begin n_fail++; $display("FAIL midrst_bus got addra=%h dina=%h data=%h want 0", fbuff_addra_o, fbuff_dina_o, rd_data_o); end
    n_checks++; if (dut.burst_ctr !== 4'd0) begin n_fail++; $display("FAIL midrst_burst got %0d want 0", dut.burst_ctr); end
    rd_req = 1'b0;
    #3 rstn = 1'b1;
    rsp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_rsp_o) rsp_cnt++;
    end
    n_checks++; if (rsp_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_rsp got %0d want 0", rsp_cnt); end
    do_read(13'd5, d, e, se, lat);
    n_checks++; if (d !== 48'hABC_DEF_123_456 || lat !== 4) begin n_fail++; $display("FAIL midrst_recover got data=%h lat=%0d want abcdef123456/4", d, lat); end
    tick();
  endtask

  initial begin
    rstn = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 4800; i++) mem[i] = 48'(i);
    mem[5] = 48'hABC_DEF_123_456;
    repeat (3) tick();
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back_writes();
    test_starvation();
    test_simultaneous();
    test_out_of_range();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
